// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 codes and alignment check for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3 == F3_H || f3 == F3_HU) ? off[0] :
           (f3 == F3_B || f3 == F3_BU) ? 1'b0 : (off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: request/response bus between the load/store unit and data memory
interface lsu_mem_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  modport master(output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
                 input mem_req_ready, mem_rsp_valid, mem_rsp_rdata);
  modport slave(input mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
                output mem_req_ready, mem_rsp_valid, mem_rsp_rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store byte-lane placement and load byte/half extraction with sign/zero extension
module lsu_align (
  input  logic [2:0]  i_st_f3,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  input  logic [2:0]  i_ld_f3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_load
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  // funct3[1] set means word (covers the undefined codes), funct3[0] half, funct3[2] unsigned
  always_comb begin
    w_byte  = 8'(i_rdata >> {i_ld_off, 3'b000});
    w_half  = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_wmask = i_st_f3[1] ? 4'hf : (i_st_f3[0] ? 4'h3 : 4'h1) << i_st_off;
    o_wdata = i_st_f3[1] ? i_st_data : i_st_f3[0] ? {2{i_st_data[15:0]}} : {4{i_st_data[7:0]}};
    o_load  = i_ld_f3[1] ? i_rdata :
              i_ld_f3[0] ? {{16{~i_ld_f3[2] & w_half[15]}}, w_half} :
                           {{24{~i_ld_f3[2] & w_byte[7]}}, w_byte};
  end
endmodule

// File: rtl/lsu_mem.sv
// lsu_mem: load/store unit running the data-memory handshake and producing one lsu_done per instruction
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  lsu_mem_if.master   mem,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] load_data
);
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid, r_we, r_done, r_err;
  logic [31:0]       r_addr, r_wdata, r_load;
  logic [3:0]        r_wmask;
  logic [2:0]        r_f3;
  logic [31:0]       w_wdata, w_load;
  logic [3:0]        w_wmask;
  logic              w_mem, w_mis, w_to;
  assign w_mem = is_load | is_store;
  assign w_mis = misaligned(funct3, addr[1:0]);
  assign w_to  = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  lsu_align u_align (
    .i_st_f3  (funct3),
    .i_st_off (addr[1:0]),
    .i_st_data(store_data),
    .i_ld_f3  (r_f3),
    .i_ld_off (r_addr[1:0]),
    .i_rdata  (mem.mem_rsp_rdata),
    .o_wdata  (w_wdata),
    .o_wmask  (w_wmask),
    .o_load   (w_load)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_load  <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (inst_valid) begin
          if (!w_mem || w_mis) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_err   <= w_mem;
          end else begin
            r_state <= REQ;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_we    <= is_store & ~is_load;
            r_addr  <= addr;
            r_wdata <= w_wdata;
            r_wmask <= is_load ? 4'h0 : w_wmask;
            r_f3    <= funct3;
          end
        end
        // a response arriving on the last allowed cycle still completes normally
        REQ, RESP: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_state == RESP && mem.mem_rsp_valid) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            if (!r_we) r_load <= w_load;
          end else if (w_to) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_load  <= '0;
            r_valid <= 1'b0;
          end else if (r_state == REQ && mem.mem_req_ready) begin
            r_state <= RESP;
            r_valid <= 1'b0;
          end
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end
  assign mem.mem_req_valid = r_valid;
  assign mem.mem_req_we    = r_we;
  assign mem.mem_req_addr  = {r_addr[31:2], 2'b00};
  assign mem.mem_req_wdata = r_wdata;
  assign mem.mem_req_wmask = r_wmask;
  assign lsu_done          = r_done;
  assign lsu_err           = r_err;
  assign load_data         = r_load;
endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: directed and randomized checks of lsu_mem against a spec-level reference model
module tb_lsu_mem;
  import lsu_pkg::*;
  logic        clk = 1'b0;
  logic        rst, inst_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        lsu_done, lsu_err;
  logic [31:0] load_data;
  int          tests = 0, fails = 0;
  logic [31:0] exp_ld = '0;
  lsu_mem_if bus();
  lsu_mem #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .mem(bus),
    .lsu_done(lsu_done), .lsu_err(lsu_err), .load_data(load_data)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 1;
      F3_H, F3_HU: return 2;
      default:     return 4;
    endcase
  endfunction
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[int'(off) * 8 +: 8];
    h = rd[int'(off[1]) * 16 +: 16];
    case (f3)
      F3_B:    return 32'($signed(b));
      F3_BU:   return 32'(b);
      F3_H:    return 32'($signed(h));
      F3_HU:   return 32'(h);
      default: return rd;
    endcase
  endfunction
  function automatic logic [3:0] ref_wmask(input logic [2:0] f3, input logic [1:0] off);
    int sz;
    sz = size_of(f3);
    return sz == 4 ? 4'hf : 4'((sz == 2 ? 3 : 1) << off);
  endfunction
  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int sz;
    sz = size_of(f3);
    return sz == 4 ? sd : sz == 2 ? {sd[15:0], sd[15:0]} : {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
  endfunction
  task automatic do_inst(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int rdy, input int rsp);
    logic mem_op, we, mis;
    mem_op = ld | st;
    we     = st & ~ld;
    mis    = mem_op && (int'(a[1:0]) % size_of(f3) != 0);
    inst_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    step;
    if (!mem_op || mis) begin
      chk("done_short", lsu_done, 1);
      chk("err_short", lsu_err, mem_op);
      chk("ld_keep", load_data, exp_ld);
      chk("no_req", bus.mem_req_valid, 0);
    end else begin
      for (int i = 0; i <= rdy; i++) begin
        chk("req_valid", bus.mem_req_valid, 1);
        chk("req_addr", bus.mem_req_addr, {a[31:2], 2'b00});
        chk("req_we", bus.mem_req_we, we);
        chk("req_wmask", bus.mem_req_wmask, we ? ref_wmask(f3, a[1:0]) : 4'h0);
        if (we) chk("req_wdata", bus.mem_req_wdata, ref_wdata(f3, sd));
        chk("done_busy", lsu_done, 0);
        bus.mem_rsp_valid = 1'($urandom_range(0, 1));
        bus.mem_rsp_rdata = $urandom;
        bus.mem_req_ready = (i == rdy);
        step;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
      end
      chk("req_drop", bus.mem_req_valid, 0);
      for (int i = 0; i <= rsp; i++) begin
        chk("done_wait", lsu_done, 0);
        bus.mem_rsp_valid = (i == rsp);
        bus.mem_rsp_rdata = rd;
        step;
        bus.mem_rsp_valid = 1'b0;
      end
      if (!we) exp_ld = ref_load(f3, a[1:0], rd);
      chk("done", lsu_done, 1);
      chk("err", lsu_err, 0);
      chk("load_data", load_data, exp_ld);
    end
    inst_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    step;
    chk("done_pulse", lsu_done, 0);
  endtask
  initial begin
    rst = 1'b1; inst_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = '0; addr = '0; store_data = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
    step; step;
    chk("rst_valid", bus.mem_req_valid, 0);
    chk("rst_done", lsu_done, 0);
    chk("rst_err", lsu_err, 0);
    chk("rst_load", load_data, 0);
    rst = 1'b0;
    step;
    do_inst(0, 0, F3_W, 32'h1234_5678, 0, 0, 0, 0);
    do_inst(1, 0, F3_B, 32'h8000_0003, 0, 32'h80FF_1234, 0, 0);
    chk("lb_sext", load_data, 32'hFFFF_FF80);
    do_inst(1, 0, F3_BU, 32'h8000_0003, 0, 32'h80FF_1234, 0, 0);
    chk("lbu_zext", load_data, 32'h0000_0080);
    do_inst(0, 1, F3_H, 32'h8000_0102, 32'h0000_BEEF, 0, 4, 0);
    do_inst(1, 0, F3_W, 32'h8000_0006, 0, 0, 0, 0);
    chk("mis_keep", load_data, 32'h0000_0080);
    // reset while a request is outstanding
    inst_valid = 1'b1; is_load = 1'b1; funct3 = F3_W; addr = 32'h0000_0200;
    step;
    chk("req_before_rst", bus.mem_req_valid, 1);
    rst = 1'b1;
    step;
    chk("rst_req_drop", bus.mem_req_valid, 0);
    rst = 1'b0;
    step;
    // reset while waiting for the response
    bus.mem_req_ready = 1'b1;
    step;
    bus.mem_req_ready = 1'b0;
    chk("in_resp", bus.mem_req_valid, 0);
    rst = 1'b1;
    step;
    rst = 1'b0; inst_valid = 1'b0; is_load = 1'b0;
    chk("rst_resp_valid", bus.mem_req_valid, 0);
    chk("rst_resp_done", lsu_done, 0);
    chk("rst_resp_load", load_data, 0);
    exp_ld = '0;
    step;
    do_inst(1, 0, F3_W, 32'h8000_0010, 0, 32'hCAFE_BABE, 0, 0);
    // timeout with ready never asserted
    inst_valid = 1'b1; is_load = 1'b1; funct3 = F3_W; addr = 32'h0000_0040;
    for (int i = 1; i <= 8; i++) begin
      step;
      chk("to_valid", bus.mem_req_valid, 1);
      chk("to_busy", lsu_done, 0);
    end
    step;
    chk("to_done", lsu_done, 1);
    chk("to_err", lsu_err, 1);
    chk("to_load", load_data, 0);
    chk("to_drop", bus.mem_req_valid, 0);
    exp_ld = '0;
    inst_valid = 1'b0; is_load = 1'b0;
    step;
    chk("to_pulse", lsu_done, 0);
    for (int n = 0; n < 80; n++) begin
      int          kind;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      f3 = kind == 2 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 2) == 0) a[1] = 1'b0;
      do_inst(kind == 1 || kind == 3, kind >= 2, f3, a, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 2));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
